receiver: RTL and testbench
===========================

Name: receiver

Overview:
UART receive path that deserializes an asynchronous serial line into parallel words. Frame is 8N1-style: start bit 0, WORD_SIZE data bits LSB first, stop bit 1, each bit PULSE_WIDTH clocks long. It is the pair of the UART transmitter and shares its frame format and bit timing. It feeds a downstream consumer through a valid/ready handshake and reports framing and overrun errors.

Parameters:
WORD_SIZE, 8, data bits per frame.
PULSE_WIDTH, 4, clocks per bit (CLOCK_FREQ/BAUD); must be >= 4.
PACKET_SIZE, 10, start + WORD_SIZE + stop; fixed at WORD_SIZE+2.

Ports:
clk  input  1  system clock.
rstn  input  1  reset, asynchronous, active-low.
rx  input  1  serial line, asynchronous to clk, idles high.
rx_ready  input  1  consumer accepts rx_data this cycle.
rx_data  output  WORD_SIZE  received word, bit 0 = first data bit on line.
rx_valid  output  1  rx_data holds an unconsumed word.
frame_err  output  1  one-cycle pulse: stop bit sampled 0.
overrun_err  output  1  one-cycle pulse: word completed while previous word still unconsumed.

Behaviour:
- Reset (async, rstn=0): state IDLE; rx_data=0; rx_valid=0; frame_err=0; overrun_err=0; counters 0; synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s); all logic uses rx_s only. This adds 2 cycles of latency.
- Counters: clk_cnt width $clog2(PULSE_WIDTH); bit_cnt width $clog2(WORD_SIZE+1). HALF = PULSE_WIDTH/2.
- IDLE: when rx_s==0, go to START with clk_cnt=0.
- START: increment clk_cnt. At clk_cnt==HALF-1, sample rx_s.
  - rx_s==0: go to DATA with clk_cnt=0 and bit_cnt=0.
  - rx_s==1: false start (glitch); return to IDLE with no outputs.
- DATA: at clk_cnt==PULSE_WIDTH-1 (mid-bit), set clk_cnt=0, shift the sample in at the MSB of the shift register (right shift), and increment bit_cnt.
  - After WORD_SIZE samples, go to STOP.
  - Otherwise clk_cnt increments.
- STOP: at clk_cnt==PULSE_WIDTH-1, sample and return to IDLE.
  - Sample 1: the word completes.
  - Sample 0: frame_err pulses 1 cycle, the word is discarded, and rx_valid/rx_data are unchanged.
  - In either case, returning to IDLE on a line still 0 re-triggers START.
- Word completion:
  - rx_valid==0, or rx_ready==1 in that cycle: load rx_data and set rx_valid=1.
  - rx_valid==1 and rx_ready==0: overrun_err pulses 1 cycle; the new word is dropped and the held word is kept.
- Handshake: rx_valid clears on the cycle after rx_valid&&rx_ready, unless a word completes in the same cycle, in which case rx_valid stays 1 with the new data.
  - rx_data is stable while rx_valid=1 and rx_ready=0.
  - rx_ready while rx_valid=0 is ignored.
- Latency: from the rx falling edge at the pin to rx_valid=1 is 2 + HALF + WORD_SIZE*PULSE_WIDTH + PULSE_WIDTH + 1 clocks (±1 for edge phase).
- Reset mid-frame aborts immediately. After release, the block waits in IDLE for rx_s==0.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: every DATA and STOP bit value is the 2-of-3 majority of rx_s captured at clk_cnt = PULSE_WIDTH-3, PULSE_WIDTH-2 and PULSE_WIDTH-1. A single-cycle glitch inside a bit does not corrupt data. The START check stays single-sample.
- Undefined: single sample at clk_cnt==PULSE_WIDTH-1 with no extra flops.

Decomposition:
- uart_pkg: rx state enum {IDLE, START, DATA, STOP} as logic[1:0], default WORD_SIZE/PULSE_WIDTH constants, and a frame-bits function shared with the transmitter.
- Sub-module uart_sync: parameterizable 2-flop synchronizer with reset value 1, instantiated on rx.

Test Plan:
- Use PULSE_WIDTH=4. Drive frame 0x A5 (line 0,1,0,1,0,0,1,0,1,1) with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5; frame_err=0; overrun_err=0.
- Send 0x3C and 0x81 back-to-back with rx_ready=0 -> 0x3C held with rx_valid=1; overrun_err pulses once at the second stop; rx_data stays 0x3C until rx_ready.
- Send frame 0x55 with stop bit 0 -> frame_err single pulse; rx_valid stays 0. Then a good frame 0x0F -> rx_data=0x0F.
- Drive a 1-cycle low glitch on an idle line -> false start, back to IDLE, no outputs. A following frame 0xFF is received correctly.
- Assert rstn=0 in the middle of data bit 4, release, then send 0x12 -> rx_data=0x12 with no stale bits; all outputs 0 during reset.
- With UART_RX_MAJORITY_EN: 1-cycle inverted glitch at the mid-sample of each data bit of 0x99 -> rx_data=0x99. Without the macro: same stimulus -> rx_data=0x66.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame definitions for the receive and transmit paths.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
   localparam int DEF_WORD_SIZE = 8;
   localparam int DEF_PULSE_WIDTH = 4;
   // Line order LSB first: start bit at index 0, stop bit at the top.
   function automatic logic [DEF_WORD_SIZE+1:0] frame_bits(input logic [DEF_WORD_SIZE-1:0] word);
      return {1'b1, word, 1'b0};
   endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for asynchronous inputs, reset to RST_VAL.
module uart_sync #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] s1_q, s2_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end
   assign q = s2_q;
endmodule

// File: rtl/receiver.sv
// receiver: UART 8N1 deserializer with valid/ready output and framing/overrun pulses.
// Define UART_RX_MAJORITY_EN to vote data/stop bits over three samples per bit.
module receiver import uart_pkg::*; #(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int PULSE_WIDTH = DEF_PULSE_WIDTH
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [WORD_SIZE-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun_err
);
   localparam int CW = $clog2(PULSE_WIDTH);
   localparam int BW = $clog2(WORD_SIZE + 1);
   localparam int HALF = PULSE_WIDTH / 2;
   rx_state_e state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
   logic rx_s, bit_val, last, done;
   uart_sync #(.W(1), .RST_VAL(1'b1)) u_sync (.clk(clk), .rstn(rstn), .d(rx), .q(rx_s));
   assign last = clk_cnt_q == CW'(PULSE_WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
   logic [1:0] maj_q, maj_d;
   always_comb begin
      maj_d = maj_q;
      if (state_q == DATA || state_q == STOP) begin
         if (clk_cnt_q == CW'(PULSE_WIDTH - 3)) maj_d[0] = rx_s;
         if (clk_cnt_q == CW'(PULSE_WIDTH - 2)) maj_d[1] = rx_s;
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) maj_q <= 2'b11;
      else maj_q <= maj_d;
   end
   assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
   assign bit_val = rx_s;
`endif
   always_comb begin
      state_d = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d = shift_q;
      rx_data_d = rx_data_q;
      rx_valid_d = rx_valid_q & ~rx_ready;
      frame_err_d = 1'b0;
      overrun_err_d = 1'b0;
      done = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               clk_cnt_d = '0;
            end
         end
         START: begin
            if (clk_cnt_q == CW'(HALF - 1)) begin
               state_d = rx_s ? IDLE : DATA;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
            end else clk_cnt_d = clk_cnt_q + 1'b1;
         end
         DATA: begin
            if (last) begin
               clk_cnt_d = '0;
               shift_d = {bit_val, shift_q[WORD_SIZE-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BW'(WORD_SIZE - 1)) state_d = STOP;
            end else clk_cnt_d = clk_cnt_q + 1'b1;
         end
         default: begin
            if (last) begin
               state_d = IDLE;
               clk_cnt_d = '0;
               done = bit_val;
               frame_err_d = ~bit_val;
            end else clk_cnt_d = clk_cnt_q + 1'b1;
         end
      endcase
      // A consumer taking the held word this cycle frees the slot for the new one.
      if (done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d = shift_q;
            rx_valid_d = 1'b1;
         end else overrun_err_d = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q <= '0;
         rx_data_q <= '0;
         rx_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q <= shift_d;
         rx_data_q <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end
   assign rx_data = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun_err = overrun_err_q;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: scoreboard bench for the UART receiver at PULSE_WIDTH=4.
module tb_receiver;
   logic clk = 1'b0, rstn = 1'b0, rx = 1'b1, rx_ready = 1'b0, rdy = 1'b0;
   logic [7:0] rx_data;
   logic rx_valid, frame_err, overrun_err;
   int n_checks = 0, n_fail = 0, fe_cnt = 0, ov_cnt = 0;
   logic [7:0] sb[$];
   receiver #(.WORD_SIZE(8), .PULSE_WIDTH(4)) dut (
      .clk(clk), .rstn(rstn), .rx(rx), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun_err(overrun_err)
   );
   always #5 clk = ~clk;
   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   // One clock: drive line and ready after the edge, then score the word the consumer takes.
   task automatic cycle(input logic v);
      logic [7:0] exp;
      @(posedge clk);
      #1 rx = v;
      rx_ready = rdy;
      @(negedge clk);
      if (rx_valid && rx_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got %h expected none", rx_data);
         end else begin
            exp = sb.pop_front();
            if (rx_data !== exp) begin
               n_fail++;
               $display("FAIL sb_word got %h expected %h", rx_data, exp);
            end
         end
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun_err === 1'b1) ov_cnt++;
   endtask
   task automatic idle(input int n);
      repeat (n) cycle(1'b1);
   endtask
   task automatic send(input logic [7:0] d, input logic stop, input logic glitch);
      logic b;
      for (int i = 0; i < 10; i++) begin
         b = (i == 0) ? 1'b0 : (i == 9) ? stop : d[i-1];
         for (int p = 0; p < 4; p++) cycle(b ^ (glitch && i >= 1 && i <= 8 && p == 2));
      end
   endtask
   task automatic check_drained(input string name);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s pending=%0d expected 0", name, sb.size());
      end
   endtask
   task automatic test_reset;
      #2;
      n_checks += 4;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b expected 0", rx_valid); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h expected 00", rx_data); end
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr got %b expected 0", frame_err); end
      if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL rst_oerr got %b expected 0", overrun_err); end
      idle(3);
      rstn = 1'b1;
      idle(4);
      n_checks++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b expected 0", rx_valid); end
   endtask
   task automatic test_basic;
      int fe0 = fe_cnt, ov0 = ov_cnt;
      rdy = 1'b1;
      sb.push_back(8'hA5);
      send(8'hA5, 1'b1, 1'b0);
      idle(4);
      check_drained("basic_a5");
      n_checks += 3;
      if (fe_cnt != fe0) begin n_fail++; $display("FAIL basic_ferr got %0d expected %0d", fe_cnt, fe0); end
      if (ov_cnt != ov0) begin n_fail++; $display("FAIL basic_oerr got %0d expected %0d", ov_cnt, ov0); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clear got %b expected 0", rx_valid); end
   endtask
   task automatic test_back_to_back;
      int ov0 = ov_cnt;
      rdy = 1'b0;
      idle(1);
      sb.push_back(8'h3C);
      send(8'h3C, 1'b1, 1'b0);
      send(8'h81, 1'b1, 1'b0);
      idle(3);
      n_checks += 3;
      if (ov_cnt != ov0 + 1) begin n_fail++; $display("FAIL ovr_count got %0d expected %0d", ov_cnt, ov0 + 1); end
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b expected 1", rx_valid); end
      if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ovr_hold got %h expected 3c", rx_data); end
      rdy = 1'b1;
      idle(2);
      check_drained("ovr_consume");
      n_checks++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear got %b expected 0", rx_valid); end
   endtask
   task automatic test_frame_err;
      int fe0 = fe_cnt;
      rdy = 1'b1;
      send(8'h55, 1'b0, 1'b0);
      idle(6);
      n_checks += 2;
      if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL ferr_count got %0d expected %0d", fe_cnt, fe0 + 1); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b expected 0", rx_valid); end
      sb.push_back(8'h0F);
      send(8'h0F, 1'b1, 1'b0);
      idle(4);
      check_drained("ferr_recover_0f");
   endtask
   task automatic test_false_start;
      int fe0 = fe_cnt, ov0 = ov_cnt;
      idle(2);
      cycle(1'b0);
      idle(8);
      n_checks += 2;
      if (rx_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
         n_fail++;
         $display("FAIL glitch_outputs valid=%b ferr=%0d oerr=%0d expected 0/%0d/%0d", rx_valid, fe_cnt, ov_cnt, fe0, ov0);
      end
      sb.push_back(8'hFF);
      send(8'hFF, 1'b1, 1'b0);
      idle(4);
      if (sb.size() != 0) begin n_fail++; $display("FAIL glitch_ff pending=%0d expected 0", sb.size()); end
   endtask
   task automatic test_reset_mid;
      logic [7:0] d = 8'hAA;
      logic b;
      rdy = 1'b0;
      send(8'h5A, 1'b1, 1'b0);
      idle(2);
      n_checks++;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b expected 1", rx_valid); end
      for (int c = 0; c < 22; c++) begin
         b = (c < 4) ? 1'b0 : d[c/4-1];
         cycle(b);
      end
      rstn = 1'b0;
      #1;
      n_checks += 4;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b expected 0", rx_valid); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %h expected 00", rx_data); end
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ferr got %b expected 0", frame_err); end
      if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_oerr got %b expected 0", overrun_err); end
      idle(3);
      rstn = 1'b1;
      idle(3);
      rdy = 1'b1;
      sb.push_back(8'h12);
      send(8'h12, 1'b1, 1'b0);
      idle(4);
      check_drained("mid_rst_12");
   endtask
   task automatic test_majority;
      rdy = 1'b1;
`ifdef UART_RX_MAJORITY_EN
      sb.push_back(8'h99);
`else
      sb.push_back(8'h66);
`endif
      send(8'h99, 1'b1, 1'b1);
      idle(4);
      check_drained("majority_99");
   endtask
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_frame_err();
      test_false_start();
      test_reset_mid();
      test_majority();
      check_drained("final_leftover");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
